// File: rtl/grf.sv
// grf: 32 x 32-bit MIPS general-purpose register file with two combinational read ports
// and one synchronous write port. Define GRF_BYPASS_EN to forward the pending write to the reads.
module grf #(
    parameter int REG_COUNT = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       PC,
    input  logic [4:0]        A1,
    input  logic [4:0]        A2,
    input  logic [4:0]        A3,
    input  logic              WE,
    input  logic [DATA_W-1:0] WD,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2
);

    logic [DATA_W-1:0] regs [REG_COUNT];
    logic              commit;

    // $0 is excluded here, so regs[0] keeps its reset value of zero forever.
    assign commit = WE && (A3 != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[A3] <= WD;
        end
    end

`ifdef GRF_BYPASS_EN
    logic fwd1;
    logic fwd2;

    // Forwarding stays off during reset so every read returns 0 while it is held.
    assign fwd1 = commit && !reset && (A1 == A3);
    assign fwd2 = commit && !reset && (A2 == A3);

    always_comb begin
        RD1 = regs[A1];
        RD2 = regs[A2];
        if (fwd1) RD1 = WD;
        if (fwd2) RD2 = WD;
    end
`else
    always_comb begin
        RD1 = regs[A1];
        RD2 = regs[A2];
    end
`endif

`ifndef SYNTHESIS
    // Architectural write trace, matched line-for-line against the course reference.
    always @(posedge clk) begin
        if (!reset && commit) begin
            $display("@%h: $%d <= %h", PC, A3, WD);
        end
    end
`endif

endmodule

// File: doc/grf.md
# grf

General-purpose register file for the single-cycle MIPS datapath: 32 × 32-bit registers, two combinational read ports and one synchronous write port. The read data drives the ALU's `In1` and `In2` operands (`In2` through the immediate mux), and the write port takes the ALU result, memory load data or link address from the writeback mux. `$0` is hardwired to zero. Every architectural write is reported on the simulation console for comparison against the course reference trace.

## Interface
Parameters:
- `REG_COUNT`, 32, number of registers. Fixed at 32; the address width below assumes it.
- `DATA_W`, 32, register width.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high; clears every register.
- `PC`  input  32  PC of the instruction performing the write; used only for the trace.
- `A1`  input  5  read address, port 1.
- `A2`  input  5  read address, port 2.
- `A3`  input  5  write address.
- `WE`  input  1  write enable.
- `WD`  input  32  write data.
- `RD1`  output  32  read data, port 1; drives ALU `In1`.
- `RD2`  output  32  read data, port 2; drives ALU `In2` and store data.

## Operation
- Storage is 32 registers. Register 0 is never written and always reads `32'h0`.
- Reads are purely combinational: `RD1 = reg[A1]`, `RD2 = reg[A2]`.
- Write: on a rising `clk` edge with `WE=1`, `reset=0` and `A3!=0`, `reg[A3] <= WD`.
- `WE=1` with `A3=0` is a legal no-op. No register changes and no trace line is produced.
- Trace: on every committed write (as defined above), emit exactly one line in the format `@%h: $%d <= %h`, using `PC`, `A3` and `WD` sampled at the edge. Emit nothing in any other cycle.
- Reset: while `reset=1`, all registers read 0, regardless of `clk`. No writes commit and no trace is emitted.
- Deasserting reset produces no write. The first write can commit on the first rising edge with `reset=0`.
- Both read ports may address the same register at the same time; each returns the same value.
- There is no arithmetic. Data passes through unmodified, with no sign or width conversion.

## Timing
- Read latency is 0 cycles (combinational from `A1`/`A2` to `RD1`/`RD2`).
- Write latency is 1 edge. Without bypass, the new value is visible on `RD*` immediately after the committing edge.
- Reset values: `RD1=RD2=32'h0` for every address while `reset=1`.
- Reset asserted in the same cycle as `WE=1`: reset wins. The register stays 0 and no trace is emitted.
- Read and write of the same register in the same cycle (`A1==A3`, `WE=1`), no bypass: `RD1` shows the old value until the edge and the new value after it.

## Configuration
- `GRF_BYPASS_EN` defined: internal write-to-read forwarding is enabled.
  - If `WE=1`, `A3!=0` and `A1==A3`, then `RD1=WD` combinationally in the same cycle, before the edge.
  - `RD2` behaves the same way with `A2`.
  - Reads of `$0` still return 0.
  - Forwarding is suppressed while `reset=1`.
- `GRF_BYPASS_EN` undefined: reads return stored contents only, with no forwarding path.
- Storage, trace and reset behaviour are identical in both builds.

## Test plan
- **Reset clear.** Write `$5=32'hDEADBEEF`, then pulse `reset` asynchronously mid-cycle.
  - Response: `RD1` reads 0 for `A1=5` immediately after reset rises, before any clock edge.
- **Basic write/read.** `WE=1`, `A3=8`, `WD=32'h12345678`, `PC=32'h00003000`, one edge; then `A1=8`, `A2=8`.
  - Response: `RD1=RD2=32'h12345678`; trace `@00003000: $ 8 <= 12345678`.
- **$0 protection.** `WE=1`, `A3=0`, `WD=32'hFFFFFFFF`, one edge.
  - Response: `RD1` for `A1=0` is 0 and no trace line appears.
- **Same-cycle read/write.** `$3=1`; then `WE=1`, `A3=3`, `WD=2`, `A1=3`, `A2=3` before the edge.
  - Response without the macro: `RD1=RD2=1` before the edge and 2 after.
  - Response with `GRF_BYPASS_EN`: 2 both before and after the edge.
- **Reset/write collision.** `reset=1`, `WE=1`, `A3=7`, `WD=32'hA5A5A5A5` across one edge, then `reset=0`.
  - Response: `RD1` for `A1=7` is 0 and no trace line appears.
- **Full sweep.** Write `reg[i]=i*32'h01010101` for `i=1..31` on consecutive edges.
  - Response: each register reads back its own value on both ports, and exactly 31 trace lines appear.
